// File: rtl/instr_encoder_pkg.sv
// Shared encode/decode definitions: opcode map, class enum and field positions.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    OP_ADDI, OP_ALUI, OP_LOAD, OP_STORE, OP_LUI, OP_JAL, OP_BRANCH, OP_RSVD
  } op_cls_e;

  localparam logic [6:0] OPC_ADDI   = 7'h1B;
  localparam logic [6:0] OPC_ALUI   = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h38;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_BRANCH = 7'h63;

  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } enc_t;

  function automatic logic [6:0] opcode_of(input op_cls_e op);
    case (op)
      OP_ADDI:   return OPC_ADDI;
      OP_ALUI:   return OPC_ALUI;
      OP_LOAD:   return OPC_LOAD;
      OP_STORE:  return OPC_STORE;
      OP_LUI:    return OPC_LUI;
      OP_JAL:    return OPC_JAL;
      OP_BRANCH: return OPC_BRANCH;
      default:   return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response bundle between the encoder and its producer/consumer.
interface instr_encoder_if #(parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [2:0]       in_funct3;
  logic [31:0]      in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err, err_count
  );
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err, err_count
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: class + operands -> instruction word and range error.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  op_cls_e     op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // Immediate fits when all bits above the encodable field equal its sign bit.
  logic ok11, ok12, ok20;
  assign ok11 = (&imm[31:11]) | ~(|imm[31:11]);
  assign ok12 = (&imm[31:12]) | ~(|imm[31:12]);
  assign ok20 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    instr = '0;
    err   = 1'b0;
    case (op)
      OP_ADDI, OP_ALUI, OP_LOAD: begin
        instr[31:20]          = imm[11:0];
        instr[RS1_LSB +: 5]   = rs1;
        instr[F3_LSB +: 3]    = funct3;
        instr[RD_LSB +: 5]    = rd;
        err                   = !ok11;
      end
      OP_STORE: begin
        instr[31:25]          = imm[11:5];
        instr[RS2_LSB +: 5]   = rs2;
        instr[RS1_LSB +: 5]   = rs1;
        instr[F3_LSB +: 3]    = funct3;
        instr[11:7]           = imm[4:0];
        err                   = !ok11;
      end
      OP_LUI: begin
        instr[31:12]          = imm[31:12];
        instr[RD_LSB +: 5]    = rd;
        err                   = |imm[11:0];
      end
      OP_JAL: begin
        instr[31]             = imm[20];
        instr[30:21]          = imm[10:1];
        instr[20]             = imm[11];
        instr[19:12]          = imm[19:12];
        instr[RD_LSB +: 5]    = rd;
        err                   = imm[0] | !ok20;
      end
      OP_BRANCH: begin
        instr[31]             = imm[12];
        instr[30:25]          = imm[10:5];
        instr[RS2_LSB +: 5]   = rs2;
        instr[RS1_LSB +: 5]   = rs1;
        instr[F3_LSB +: 3]    = funct3;
        instr[11:8]           = imm[4:1];
        instr[7]              = imm[11];
        err                   = imm[0] | !ok12;
      end
      default: err = 1'b1;
    endcase
    if (op != OP_RSVD) instr[6:0] = opcode_of(op);
  end

endmodule

// File: rtl/instr_encoder.sv
// Encoder top: packs accepted requests into a small in-order output FIFO and counts errors.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8,
  parameter bit STRICT = 1'b0
) (
  input logic           clk,
  input logic           rst,
  instr_encoder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  enc_t             enc;
  enc_t             mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             accept, push, pop;

  instr_pack u_pack (
    .op     (op_cls_e'(bus.in_op)),
    .rd     (bus.in_rd),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .funct3 (bus.in_funct3),
    .imm    (bus.in_imm),
    .instr  (enc.instr),
    .err    (enc.err)
  );

  // in_ready depends on registered occupancy only, so a pop never frees a slot the same cycle.
  assign bus.in_ready  = (count_q != FULL);
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q].instr : '0;
  assign bus.out_err   = bus.out_valid & mem_q[rd_ptr_q].err;
  assign bus.err_count = err_cnt_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && !(STRICT && enc.err);
  assign pop    = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(push) - CW'(pop);
    err_cnt_d = err_cnt_q;
    if (accept && enc.err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: outputs are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc;
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench: a lenient and a strict encoder see the same accepted request stream.
module tb_instr_encoder;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0, bad = 0;
  int   cyc = 0, pops = 0, stalls = 0, acc_cyc = 0, pop_cyc = 0;
  int   exp_ec = 0;
  exp_t q[$], qs[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  instr_encoder_if #(.CNT_W(8)) bi ();
  instr_encoder_if #(.CNT_W(8)) bs ();

  instr_encoder #(.DEPTH(2), .CNT_W(8), .STRICT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bi.slave));
  instr_encoder #(.DEPTH(2), .CNT_W(8), .STRICT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bs.slave));

  // Strict copy only sees requests the lenient copy accepts, so both count identically.
  assign bs.in_valid  = bi.in_valid && bi.in_ready;
  assign bs.in_op     = bi.in_op;
  assign bs.in_rd     = bi.in_rd;
  assign bs.in_rs1    = bi.in_rs1;
  assign bs.in_rs2    = bi.in_rs2;
  assign bs.in_funct3 = bi.in_funct3;
  assign bs.in_imm    = bi.in_imm;
  assign bs.out_ready = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [4:0] rd, rs1, rs2,
                      input logic [2:0] f3, input logic [31:0] imm,
                      input logic [31:0] ei, input logic ee);
    int n = 0;
    @(negedge clk);
    bi.in_valid = 1'b1; bi.in_op = op; bi.in_rd = rd; bi.in_rs1 = rs1;
    bi.in_rs2 = rs2; bi.in_funct3 = f3; bi.in_imm = imm;
    while (!bi.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (!bi.in_ready) begin
      chk("send_timeout", 32'(bi.in_ready), 32'd1);
      bi.in_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    @(posedge clk);
    q.push_back('{ei, ee});
    if (!ee) qs.push_back('{ei, ee});
    if (ee && exp_ec != 255) exp_ec++;
  endtask

  task automatic idle();
    @(negedge clk);
    bi.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || qs.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size() + qs.size()), 32'd0);
  endtask

  // Monitor: compare every word the DUTs hand over against the queued expectation.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (bi.out_valid && bi.out_ready) begin
        pops++;
        if (q.size() == 0) chk("main_unexpected", bi.out_instr, 32'hxxxxxxxx);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("main_instr", bi.out_instr, e.instr);
          chk("main_err", 32'(bi.out_err), 32'(e.err));
        end
      end
      if (bs.out_valid) begin
        if (qs.size() == 0) chk("strict_unexpected", bs.out_instr, 32'hxxxxxxxx);
        else begin
          exp_t e;
          e = qs.pop_front();
          chk("strict_instr", bs.out_instr, e.instr);
          chk("strict_err", 32'(bs.out_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bi.in_valid = 1'b0; bi.in_op = '0; bi.in_rd = '0; bi.in_rs1 = '0;
    bi.in_rs2 = '0; bi.in_funct3 = '0; bi.in_imm = '0; bi.out_ready = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_in_ready", 32'(bi.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bi.out_valid), 32'd0);
    chk("rst_out_instr", bi.out_instr, 32'd0);
    chk("rst_out_err", 32'(bi.out_err), 32'd0);
    chk("rst_err_count", 32'(bi.err_count), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Main formats, visible one edge after accept
    send(3'd0, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF3029B, 1'b0);
    #2 chk("latency_valid", 32'(bi.out_valid), 32'd1);
    send(3'd3, 5'd0, 5'd2, 5'd8, 3'd2, 32'h0000_07F8, 32'h7E812C23, 1'b0);
    send(3'd6, 5'd0, 5'd1, 5'd2, 3'd1, 32'hFFFF_FFFC, 32'hFE209EE3, 1'b0);
    idle(); drain();

    // Errors: emitted by the lenient copy, dropped by the strict copy
    send(3'd5, 5'd0, 5'd0, 5'd0, 3'd0, 32'd3, 32'h0020006F, 1'b1);
    #2 chk("ec_jal", 32'(bi.err_count), 32'd1);
    send(3'd4, 5'd0, 5'd0, 5'd0, 3'd0, 32'h12345001, 32'h12345038, 1'b1);
    #2 chk("ec_lui", 32'(bi.err_count), 32'd2);
    send(3'd7, 5'd3, 5'd4, 5'd5, 3'd6, 32'h1234_5678, 32'h0, 1'b1);
    #2 chk("ec_rsvd", 32'(bi.err_count), 32'd3);
    chk("ec_strict", 32'(bs.err_count), 32'd3);
    idle(); drain();

    // Saturation
    for (int i = 0; i < 300; i++) send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h0, 1'b1);
    #2 chk("sat_main", 32'(bi.err_count), 32'(exp_ec));
    chk("sat_strict", 32'(bs.err_count), 32'd255);
    idle(); drain();

    // Backpressure: A, B fill the FIFO, C waits for the first pop
    @(negedge clk); bi.out_ready = 1'b0;
    send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 32'h0010009B, 1'b0);
    send(3'd1, 5'd2, 5'd3, 5'd0, 3'd7, 32'hFFFF_F800, 32'h8001F113, 1'b0);
    #2 chk("bp_in_ready_low", 32'(bi.in_ready), 32'd0);
    fork
      send(3'd2, 5'd31, 5'd31, 5'd0, 3'd2, 32'h0000_07FF, 32'h7FFFAF83, 1'b0);
      begin
        @(negedge clk); @(negedge clk); #1;
        chk("bp_hold_instr", bi.out_instr, 32'h0010009B);
        chk("bp_hold_ready", 32'(bi.in_ready), 32'd0);
        @(negedge clk);
        bi.out_ready = 1'b1;
        pop_cyc = cyc;
      end
    join
    chk("bp_c_accept", 32'(acc_cyc), 32'(pop_cyc + 1));
    idle(); drain();

    // Continuous stream: no stalls, one word per cycle
    pops = 0; stalls = 0;
    for (int i = 0; i < 10; i++)
      send(3'd0, 5'(i), 5'd0, 5'd0, 3'd0, 32'(i), (32'(i) << 20) | (32'(i) << 7) | 32'h1B, 1'b0);
    idle();
    @(negedge clk); #2;
    chk("stream_stalls", 32'(stalls), 32'd0);
    chk("stream_pops", 32'(pops), 32'd10);
    drain();

    // Reset mid-stream
    @(negedge clk); rst = 1'b1; exp_ec = 0;
    @(negedge clk); rst = 1'b0; bi.out_ready = 1'b0;
    send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1, 32'h0010009B, 1'b0);
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 32'h0, 1'b1);
    idle(); #1;
    chk("mid_err_count", 32'(bi.err_count), 32'd1);
    chk("mid_full", 32'(bi.in_ready), 32'd0);
    @(negedge clk); rst = 1'b1; #1;
    chk("mid_rst_valid", 32'(bi.out_valid), 32'd0);
    chk("mid_rst_ec", 32'(bi.err_count), 32'd0);
    chk("mid_rst_ready", 32'(bi.in_ready), 32'd1);
    q.delete(); qs.delete(); exp_ec = 0;
    @(negedge clk); rst = 1'b0; bi.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 chk("post_rst_valid", 32'(bi.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
